// File: rtl/gtx_link_pkg.sv
// Shared types and constants for the 4-lane GTX link sequencer.
package gtx_link_pkg;

  localparam int unsigned NLanes = 4;
  localparam int unsigned WordW  = 20;
  localparam int unsigned FrameW = NLanes * WordW;

  localparam logic [WordW-1:0] SyncWord = 20'h1E0F0;
  localparam logic [WordW-1:0] IdleWord = 20'h0F0F0;

  typedef enum logic [1:0] {
    StResetHold,
    StSync,
    StRun
  } link_state_e;

  // Lane k occupies bits [WordW*k +: WordW] of a packed frame.
  function automatic logic [WordW-1:0] lane_word(input logic [FrameW-1:0] frame, input int k);
    return frame[k*WordW +: WordW];
  endfunction

endpackage

// File: rtl/gtx_frame_arbiter.sv
// Service/data/idle grant with a cap on consecutive service frames while data waits.
module gtx_frame_arbiter #(
  parameter int unsigned SvcMax = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic data_valid_i,
  input  logic svc_valid_i,
  output logic grant_data_o,
  output logic grant_svc_o,
  output logic svc_stall_o
);

  localparam int unsigned CntW = $clog2(SvcMax + 1);

  logic [CntW-1:0] svc_cnt_q, svc_cnt_d;
  logic            at_max;

  // Grant decode: service wins unless data has waited through SvcMax service frames.
  always_comb begin
    at_max       = data_valid_i && (svc_cnt_q == CntW'(SvcMax));
    grant_svc_o  = en_i && svc_valid_i && !at_max;
    grant_data_o = en_i && data_valid_i && !grant_svc_o;
    svc_stall_o  = en_i && svc_valid_i && at_max;
  end

  // Count consecutive service grants only while data is pending.
  always_comb begin
    svc_cnt_d = svc_cnt_q;
    if (!en_i || !data_valid_i || grant_data_o) begin
      svc_cnt_d = '0;
    end else if (grant_svc_o && (svc_cnt_q < CntW'(SvcMax))) begin
      svc_cnt_d = svc_cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      svc_cnt_q <= '0;
    end else begin
      svc_cnt_q <= svc_cnt_d;
    end
  end

endmodule

// File: rtl/gtx_link_sequencer.sv
// GTX link bring-up (reset hold, lane sync, run) and registered lane word outputs.
module gtx_link_sequencer
  import gtx_link_pkg::*;
#(
  parameter int unsigned RstCycles  = 16,
  parameter int unsigned SyncCycles = 32,
  parameter int unsigned SvcMax     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NLanes-1:0] en_lane_i,
  input  logic              resync_i,
  input  logic [FrameW-1:0] data_frame_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  input  logic [FrameW-1:0] svc_frame_i,
  input  logic              svc_valid_i,
  output logic              svc_ready_o,
  output logic              ser_rst_b_o,
  output logic [NLanes-1:0] ser_en_lane_o,
  output logic [WordW-1:0]  ser_word0_o,
  output logic [WordW-1:0]  ser_word1_o,
  output logic [WordW-1:0]  ser_word2_o,
  output logic [WordW-1:0]  ser_word3_o,
  output logic              link_up_o,
  output logic              svc_stall_o
);

  localparam int unsigned MaxCycles = (RstCycles > SyncCycles) ? RstCycles : SyncCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  link_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              restart;
  logic              arb_en;
  logic              grant_data, grant_svc;

  logic              ser_rst_b_q, ser_rst_b_d;
  logic [NLanes-1:0] ser_en_lane_q, ser_en_lane_d;
  logic [WordW-1:0]  ser_word_q [NLanes];
  logic [WordW-1:0]  ser_word_d [NLanes];

  // Lane set change against what the serializer currently has, or an explicit request.
  assign restart = (en_lane_i != ser_en_lane_q) || resync_i;
  // No accept on the cycle the link drops back to sync.
  assign arb_en  = (state_q == StRun) && !restart;

  gtx_frame_arbiter #(
    .SvcMax (SvcMax)
  ) u_arbiter (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (arb_en),
    .data_valid_i (data_valid_i),
    .svc_valid_i  (svc_valid_i),
    .grant_data_o (grant_data),
    .grant_svc_o  (grant_svc),
    .svc_stall_o  (svc_stall_o)
  );

  // State and phase counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StResetHold;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: timed reset hold, restartable sync window, run until restart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StResetHold: begin
        if (cnt_q == CntW'(RstCycles - 1)) begin
          state_d = StSync;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSync: begin
        if (restart) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(SyncCycles - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (restart) begin
          state_d = StSync;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StResetHold;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register next values follow the state being entered.
  always_comb begin
    ser_rst_b_d   = (state_d != StResetHold);
    ser_en_lane_d = ser_rst_b_d ? en_lane_i : '0;
    for (int k = 0; k < NLanes; k++) begin
      ser_word_d[k] = '0;
      if (en_lane_i[k]) begin
        unique case (state_d)
          StSync: ser_word_d[k] = SyncWord;
          StRun: begin
            if (grant_svc) begin
              ser_word_d[k] = lane_word(svc_frame_i, k);
            end else if (grant_data) begin
              ser_word_d[k] = lane_word(data_frame_i, k);
            end else begin
              ser_word_d[k] = IdleWord;
            end
          end
          default: ser_word_d[k] = '0;
        endcase
      end
    end
  end

  // Serializer-facing output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ser_rst_b_q   <= 1'b0;
      ser_en_lane_q <= '0;
      for (int k = 0; k < NLanes; k++) begin
        ser_word_q[k] <= '0;
      end
    end else begin
      ser_rst_b_q   <= ser_rst_b_d;
      ser_en_lane_q <= ser_en_lane_d;
      for (int k = 0; k < NLanes; k++) begin
        ser_word_q[k] <= ser_word_d[k];
      end
    end
  end

  assign data_ready_o  = grant_data;
  assign svc_ready_o   = grant_svc;
  assign link_up_o     = (state_q == StRun);
  assign ser_rst_b_o   = ser_rst_b_q;
  assign ser_en_lane_o = ser_en_lane_q;
  assign ser_word0_o   = ser_word_q[0];
  assign ser_word1_o   = ser_word_q[1];
  assign ser_word2_o   = ser_word_q[2];
  assign ser_word3_o   = ser_word_q[3];

endmodule
